// File: rtl/prog_loader_ctrl.sv
// Host-side loader/sequencer for the datapath: streams a header, data block and program
// into d_mem/i_mem, runs the PC for a fixed window, then streams d_mem[1..N] back out.
module prog_loader_ctrl #(
  parameter int unsigned NUM_INSTR  = 32,
  parameter int unsigned RUN_CYCLES = 2100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic [31:0] i_mem_addra,
  output logic [31:0] i_mem_din,
  output logic        i_mem_we,
  output logic [7:0]  d_mem_addra,
  output logic [63:0] d_mem_din,
  output logic        d_mem_we,
  input  logic [63:0] d_mem_out,
  output logic        pc_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_HDR, S_LD_DATA, S_LD_INSTR, S_RUN,
    S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] icnt_q, icnt_d;
  logic [23:0] run_cnt_q, run_cnt_d;
  logic [8:0]  rcnt_q, rcnt_d;
  logic        pc_en_q, pc_en_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [31:0] i_mem_addra_q, i_mem_addra_d;
  logic [31:0] i_mem_din_q, i_mem_din_d;
  logic        i_mem_we_q, i_mem_we_d;
  logic [7:0]  d_mem_addra_q, d_mem_addra_d;
  logic [63:0] d_mem_din_q, d_mem_din_d;
  logic        d_mem_we_q, d_mem_we_d;
  logic        err_q, err_d;
  logic        xfer;

  assign in_ready    = (state_q == S_LD_HDR) || (state_q == S_LD_DATA) ||
                       (state_q == S_LD_INSTR);
  assign xfer        = in_valid && in_ready;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign pc_en       = pc_en_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign i_mem_addra = i_mem_addra_q;
  assign i_mem_din   = i_mem_din_q;
  assign i_mem_we    = i_mem_we_q;
  assign d_mem_addra = d_mem_addra_q;
  assign d_mem_din   = d_mem_din_q;
  assign d_mem_we    = d_mem_we_q;
  assign err         = err_q;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    icnt_d        = icnt_q;
    run_cnt_d     = run_cnt_q;
    rcnt_d        = rcnt_q;
    pc_en_d       = pc_en_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    i_mem_addra_d = i_mem_addra_q;
    i_mem_din_d   = i_mem_din_q;
    i_mem_we_d    = 1'b0;
    d_mem_addra_d = d_mem_addra_q;
    d_mem_din_d   = d_mem_din_q;
    d_mem_we_d    = 1'b0;
    err_d         = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LD_HDR;
          err_d   = 1'b0;
        end
      end
      S_LD_HDR: begin
        if (xfer) begin
          n_d = in_data[7:0];
          if (|in_data[63:8]) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            d_mem_addra_d = '0;
            d_mem_din_d   = in_data;
            d_mem_we_d    = 1'b1;
            cnt_d         = 9'd1;
            icnt_d        = '0;
            state_d       = (in_data[7:0] == 8'd0) ? S_LD_INSTR : S_LD_DATA;
          end
        end
      end
      S_LD_DATA: begin
        if (xfer) begin
          d_mem_addra_d = cnt_q[7:0];
          d_mem_din_d   = in_data;
          d_mem_we_d    = 1'b1;
          cnt_d         = cnt_q + 9'd1;
          if (cnt_q == {1'b0, n_q}) state_d = S_LD_INSTR;
        end
      end
      S_LD_INSTR: begin
        if (xfer) begin
          i_mem_addra_d = icnt_q;
          i_mem_din_d   = in_data[31:0];
          i_mem_we_d    = 1'b1;
          icnt_d        = icnt_q + 32'd1;
          if (icnt_q == 32'(NUM_INSTR - 1)) begin
            state_d   = S_RUN;
            run_cnt_d = '0;
          end
        end
      end
      S_RUN: begin
        // First RUN cycle overlaps the last i_mem write; pc_en rises one cycle later.
        if (run_cnt_q == 24'(RUN_CYCLES)) begin
          pc_en_d = 1'b0;
          rcnt_d  = 9'd1;
          if (n_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d       = S_RD_ADDR;
            d_mem_addra_d = 8'd1;
          end
        end else begin
          pc_en_d   = 1'b1;
          run_cnt_d = run_cnt_q + 24'd1;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        out_data_d  = d_mem_out;
        out_valid_d = 1'b1;
        state_d     = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rcnt_d      = rcnt_q + 9'd1;
          if (rcnt_q >= {1'b0, n_q}) begin
            state_d = S_DONE;
          end else begin
            state_d       = S_RD_ADDR;
            d_mem_addra_d = rcnt_d[7:0];
          end
        end
      end
      S_DONE: begin
        d_mem_addra_d = '0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      cnt_q         <= '0;
      icnt_q        <= '0;
      run_cnt_q     <= '0;
      rcnt_q        <= '0;
      pc_en_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      i_mem_addra_q <= '0;
      i_mem_din_q   <= '0;
      i_mem_we_q    <= 1'b0;
      d_mem_addra_q <= '0;
      d_mem_din_q   <= '0;
      d_mem_we_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      cnt_q         <= cnt_d;
      icnt_q        <= icnt_d;
      run_cnt_q     <= run_cnt_d;
      rcnt_q        <= rcnt_d;
      pc_en_q       <= pc_en_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      i_mem_addra_q <= i_mem_addra_d;
      i_mem_din_q   <= i_mem_din_d;
      i_mem_we_q    <= i_mem_we_d;
      d_mem_addra_q <= d_mem_addra_d;
      d_mem_din_q   <= d_mem_din_d;
      d_mem_we_q    <= d_mem_we_d;
      err_q         <= err_d;
    end
  end

endmodule
